// File: rtl/cnn_window_gen_pkg.sv
// Shared types and defaults for the CNN window generator.
// Defaults describe the first conv layer input: 28x28 pixels, 3x3 window.
package cnn_window_gen_pkg;

  localparam int ISP_BW       = 8;
  localparam int IMG_W_D      = 28;
  localparam int IMG_H_D      = 28;
  localparam int K_SIZE       = 3;
  localparam int TOTAL_PIXELS = IMG_W_D * IMG_H_D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out bundle between the fmap feeder and conv layer 0.
// The master drives pixels; the slave (window generator) drives windows.
interface cnn_window_gen_if
  import cnn_window_gen_pkg::*;
#(
  parameter int DATA_W = ISP_BW,
  parameter int K      = K_SIZE
);

  logic                    i_valid;
  logic [DATA_W-1:0]       i_pixel;
  logic                    o_valid;
  logic [K*K*DATA_W-1:0]   o_window;
  logic                    o_frame_done;
  logic                    o_busy;

  modport master (
    output i_valid, i_pixel,
    input  o_valid, o_window, o_frame_done, o_busy
  );

  modport slave (
    input  i_valid, i_pixel,
    output o_valid, o_window, o_frame_done, o_busy
  );

endinterface

// File: rtl/cnn_window_gen_line_buffer.sv
// One-row pixel delay line; read and write share the address,
// and the read returns the value stored before this beat's write.
module cnn_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 28,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to KxK sliding window (stride 1, no padding).
// Frame position is tracked purely by counting accepted beats.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int DATA_W = ISP_BW,
  parameter int IMG_W  = IMG_W_D,
  parameter int IMG_H  = IMG_H_D,
  parameter int K      = K_SIZE
) (
  input  logic            clk,
  input  logic            reset_n,
  cnn_window_gen_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = K * K * DATA_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K    = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(K - 2);

  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  state_t            state;
  state_t            state_nxt;
  logic              beat;
  logic              col_end;
  logic              frame_end;
  logic              emit;
  logic [DATA_W-1:0] col [K];
  logic [DATA_W-1:0] win [K][K];
  logic [DATA_W-1:0] win_nxt [K][K];
  logic [WW-1:0]     win_flat;

  assign beat     = bus.i_valid;
  assign col[K-1] = bus.i_pixel;

  // col[K-1] is the newest row; each buffer delays it by one more row.
  for (genvar n = 0; n < K - 1; n++) begin : g_lb
    cnn_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .AW     (CW)
    ) u_lb (
      .clk  (clk),
      .en   (beat),
      .addr (col_cnt),
      .din  (col[K-1-n]),
      .dout (col[K-2-n])
    );
  end

  always_comb begin
    col_end   = (col_cnt == COL_LAST);
    frame_end = col_end && (row_cnt == ROW_LAST);
    emit      = beat && (row_cnt >= ROW_K) && (col_cnt >= COL_K);
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = (K == 1) ? STREAM : FILL;
      FILL:    state_nxt = (row_cnt == ROW_FILL && col_end) ? STREAM : FILL;
      STREAM:  state_nxt = STREAM;
      default: state_nxt = IDLE;
    endcase
    if (frame_end) state_nxt = IDLE;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) win_nxt[i][j] = win[i][j+1];
      win_nxt[i][K-1] = col[i];
      for (int j = 0; j < K; j++)
        win_flat[(i*K+j)*DATA_W +: DATA_W] = win_nxt[i][j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt          <= '0;
      row_cnt          <= '0;
      state            <= IDLE;
      win              <= '{default: '0};
      bus.o_valid      <= 1'b0;
      bus.o_window     <= '0;
      bus.o_frame_done <= 1'b0;
      bus.o_busy       <= 1'b0;
    end else if (beat) begin
      if (frame_end) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
      state            <= state_nxt;
      win              <= win_nxt;
      bus.o_valid      <= emit;
      bus.o_frame_done <= frame_end;
      bus.o_busy       <= (state_nxt != IDLE);
      if (emit) bus.o_window <= win_flat;
    end else begin
      bus.o_valid      <= 1'b0;
      bus.o_frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: frame model + scoreboard queue + vector table.
// Covers ramp frames, idle gaps, back-to-back frames and mid-frame reset.
module tb_cnn_window_gen;
  import cnn_window_gen_pkg::*;

  localparam int DW  = 8;
  localparam int W   = 28;
  localparam int H   = 28;
  localparam int K   = 3;
  localparam int NP  = W * H;
  localparam int WW  = K * K * DW;

  typedef struct {
    logic [WW-1:0] w;
    logic          d;
  } exp_t;

  typedef struct {
    int            beat;
    logic          v;
    logic [WW-1:0] w;
    logic          d;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  cnn_window_gen_if #(.DATA_W(DW), .K(K)) bus ();

  cnn_window_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H),
    .K      (K)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   errs = 0;
  int   vcount = 0;
  int   dcount = 0;
  exp_t q[$];

  int            pos = 0;
  int            last_pos = -1;
  logic          exp_v = 1'b0;
  logic          exp_busy = 1'b0;
  logic [DW-1:0] fr [NP];
  logic          cap_v [NP];
  logic [WW-1:0] cap_w [NP];
  logic          cap_d [NP];

  function automatic void chk(string name, logic [WW-1:0] act,
                              logic [WW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [WW-1:0] mkw(int a0, int a1, int a2, int a3,
                                        int a4, int a5, int a6, int a7,
                                        int a8);
    logic [WW-1:0] r;
    r = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0],
         a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return r;
  endfunction

  // Reference model: predicts each output from the accepted pixels.
  always @(posedge clk) begin
    if (!reset_n) begin
      pos      = 0;
      exp_v    = 1'b0;
      exp_busy = 1'b0;
      last_pos = -1;
    end else begin
      exp_v    = 1'b0;
      last_pos = -1;
      if (bus.i_valid) begin
        int r, c;
        logic [WW-1:0] w;
        fr[pos] = bus.i_pixel;
        r = pos / W;
        c = pos % W;
        if (r >= K - 1 && c >= K - 1) begin
          w = '0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              w[(i*K+j)*DW +: DW] = fr[(r-K+1+i)*W + c-K+1+j];
          exp_v = 1'b1;
          q.push_back('{w: w, d: (pos == NP - 1)});
        end
        last_pos = pos;
        pos = (pos + 1) % NP;
        exp_busy = (pos != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_o_valid", WW'(bus.o_valid), '0);
      chk("rst_o_window", bus.o_window, '0);
      chk("rst_o_frame_done", WW'(bus.o_frame_done), '0);
      chk("rst_o_busy", WW'(bus.o_busy), '0);
      q.delete();
    end else begin
      chk("o_valid", WW'(bus.o_valid), WW'(exp_v));
      chk("o_busy", WW'(bus.o_busy), WW'(exp_busy));
      if (last_pos >= 0) begin
        cap_v[last_pos] = bus.o_valid;
        cap_w[last_pos] = bus.o_window;
        cap_d[last_pos] = bus.o_frame_done;
      end
      if (bus.o_valid) begin
        vcount++;
        if (bus.o_frame_done) dcount++;
        if (q.size() == 0) begin
          nvec++;
          errs++;
          $display("FAIL sb_empty: got unexpected window %h", bus.o_window);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_window", bus.o_window, e.w);
          chk("sb_frame_done", WW'(bus.o_frame_done), WW'(e.d));
        end
      end else begin
        chk("idle_frame_done", WW'(bus.o_frame_done), '0);
      end
    end
  end

  task automatic drive(input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      while ($urandom_range(99, 0) < gap) begin
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b1;
      bus.i_pixel = DW'((p % NP) % 256);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < NP; i++) cap_v[i] = 1'bx;
    vcount = 0;
    dcount = 0;
  endtask

  vec_t tbl [9];

  task automatic apply_table(string tag);
    for (int i = 0; i < 9; i++) begin
      chk({tag, "_v"}, WW'(cap_v[tbl[i].beat]), WW'(tbl[i].v));
      if (tbl[i].v) begin
        chk({tag, "_w"}, cap_w[tbl[i].beat], tbl[i].w);
        chk({tag, "_d"}, WW'(cap_d[tbl[i].beat]), WW'(tbl[i].d));
      end
    end
  endtask

  task automatic frame_totals(string tag, int nv, int nd);
    chk({tag, "_valid_count"}, WW'(vcount), WW'(nv));
    chk({tag, "_done_count"}, WW'(dcount), WW'(nd));
    chk({tag, "_sb_left"}, WW'(q.size()), '0);
  endtask

  initial begin
    tbl[0] = '{2,   1'b0, '0, 1'b0};
    tbl[1] = '{56,  1'b0, '0, 1'b0};
    tbl[2] = '{57,  1'b0, '0, 1'b0};
    tbl[3] = '{58,  1'b1, mkw(0, 1, 2, 28, 29, 30, 56, 57, 58), 1'b0};
    tbl[4] = '{84,  1'b0, '0, 1'b0};
    tbl[5] = '{85,  1'b0, '0, 1'b0};
    tbl[6] = '{86,  1'b1, mkw(28, 29, 30, 56, 57, 58, 84, 85, 86), 1'b0};
    tbl[7] = '{782, 1'b1,
               mkw(212, 213, 214, 240, 241, 242, 12, 13, 14), 1'b0};
    tbl[8] = '{783, 1'b1,
               mkw(213, 214, 215, 241, 242, 243, 13, 14, 15), 1'b1};

    bus.i_valid = 1'b0;
    bus.i_pixel = '0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    clear_caps();
    drive(NP, 0);
    idle(4);
    frame_totals("ramp", 676, 1);
    apply_table("ramp");

    clear_caps();
    drive(NP, 30);
    idle(4);
    frame_totals("gaps", 676, 1);
    apply_table("gaps");

    clear_caps();
    drive(2 * NP, 0);
    idle(4);
    frame_totals("b2b", 1352, 2);
    apply_table("b2b");

    drive(100, 0);
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);
    clear_caps();
    drive(NP, 0);
    idle(4);
    frame_totals("post_rst", 676, 1);
    apply_table("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
